// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - M-stage data-memory bridge onto a split address/data handshake bus
// Optional feature macro: DMEM_STORE_BUFFER_EN (one-entry posted-write buffer for stores).
module dmem_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memen,
  input  logic              memwrite,
  input  logic [3:0]        sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              m_hold,
  output logic [DATA_W-1:0] rdata,
  output logic              stall_mem,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateT;

  stateT             state;
  logic [DATA_W-1:0] rdataQ;
  logic              posted;
  logic              complete;
  logic              postStore;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^addr[1:0];
  assign complete       = (state == WAIT) && data_data_ok;

`ifdef DMEM_STORE_BUFFER_EN
  // A store is only posted when the pipeline really advances; a held M stage would re-present it.
  assign postStore = (state == IDLE) && memen && memwrite && !m_hold;
`else
  assign postStore = 1'b0;
`endif

  // A posted store's completion must not release a younger access waiting behind it.
  assign stall_mem = memen && !(complete && !posted) && (state != DONE) && !postStore;
  assign rdata     = complete ? data_rdata : rdataQ;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_wstrb <= 4'b0000;
      data_addr  <= '0;
      data_wdata <= '0;
      rdataQ     <= '0;
      posted     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memen) begin
            state      <= REQ;
            data_req   <= 1'b1;
            data_wr    <= memwrite;
            data_wstrb <= memwrite ? sel : 4'b0000;
            data_addr  <= {addr[ADDR_W-1:2], 2'b00};
            data_wdata <= wdata;
            posted     <= postStore;
          end
        end
        REQ: begin
          if (data_addr_ok) begin
            state    <= WAIT;
            data_req <= 1'b0;
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            if (!posted) begin
              rdataQ <= data_rdata;
            end
            state <= (m_hold && !posted) ? DONE : IDLE;
          end
        end
        DONE: begin
          if (!m_hold) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge
// Expectations come from access-latency arithmetic; build with DMEM_STORE_BUFFER_EN for posted stores.
module tb_dmem_bridge;

`ifdef DMEM_STORE_BUFFER_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, memen, memwrite, m_hold;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall_mem, data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  dmem_bridge dut (
    .clk(clk), .rst(rst), .memen(memen), .memwrite(memwrite), .sel(sel),
    .addr(addr), .wdata(wdata), .m_hold(m_hold), .rdata(rdata),
    .stall_mem(stall_mem), .data_req(data_req), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  logic        chk, expStall, expReq, expWr, chkRdata;
  logic [3:0]  expWstrb;
  logic [31:0] expAddr, expWdata, expRdata;

  int          acceptedSeen = 0;
  int          acceptedExp = 0;
  int          stallCycles, reqCycles;
  logic [31:0] lastReqAddr, okRdata;
  logic [3:0]  lastReqWstrb;
  logic        lastReqWr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      cmp("stall_mem", 32'(stall_mem), 32'(expStall));
      cmp("data_req", 32'(data_req), 32'(expReq));
      if (expReq) begin
        cmp("data_addr", data_addr, expAddr);
        cmp("data_wr", 32'(data_wr), 32'(expWr));
        cmp("data_wstrb", 32'(data_wstrb), 32'(expWstrb));
        if (expWr) cmp("data_wdata", data_wdata, expWdata);
      end
      if (chkRdata) cmp("rdata", rdata, expRdata);
      if (stall_mem) stallCycles++;
      if (data_req) begin
        reqCycles++;
        lastReqAddr  = data_addr;
        lastReqWstrb = data_wstrb;
        lastReqWr    = data_wr;
      end
      if (data_req && data_addr_ok) acceptedSeen++;
      if (data_data_ok) okRdata = rdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearStats();
    stallCycles = 0;
    reqCycles   = 0;
  endtask

  // One M-stage access: addr_ok after dAddr extra REQ cycles, data_ok after dData extra WAIT cycles,
  // then m_hold kept high for hold cycles starting on the completion cycle.
  task automatic runAccess(input logic wr, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] wd, input int dAddr, input int dData,
                           input logic [31:0] rd, input int hold);
    int   c;
    int   last;
    logic postedAcc;
    c         = 2 + dAddr + dData;
    last      = (hold > 0) ? c + hold : c;
    postedAcc = wr && POSTED;
    for (int k = 0; k <= last; k++) begin
      memen        = postedAcc ? (k == 0) : 1'b1;
      memwrite     = wr;
      sel          = s;
      addr         = a;
      wdata        = wd;
      m_hold       = (k >= c) && (k < c + hold);
      data_addr_ok = (k == 1 + dAddr);
      data_data_ok = (k == c);
      data_rdata   = (k == c) ? rd : 32'h0;
      chk          = 1'b1;
      expStall     = postedAcc ? 1'b0 : (k < c);
      expReq       = (k >= 1) && (k <= 1 + dAddr);
      expAddr      = {a[31:2], 2'b00};
      expWr        = wr;
      expWstrb     = wr ? s : 4'b0000;
      expWdata     = wd;
      chkRdata     = !wr && (k >= c);
      expRdata     = rd;
      step();
    end
    acceptedExp++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      memen = 1'b0; m_hold = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      chk = 1'b1; expStall = 1'b0; expReq = 1'b0; chkRdata = 1'b0;
      step();
    end
  endtask

  initial begin
    rst = 1'b0; memen = 1'b0; memwrite = 1'b0; sel = 4'h0; addr = 32'h0; wdata = 32'h0;
    m_hold = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    chk = 1'b0; expStall = 1'b0; expReq = 1'b0; expWr = 1'b0; chkRdata = 1'b0;
    expWstrb = 4'h0; expAddr = 32'h0; expWdata = 32'h0; expRdata = 32'h0;
    lastReqAddr = 32'h0; okRdata = 32'h0; lastReqWstrb = 4'h0; lastReqWr = 1'b0;
    clearStats();
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    cmp("reset stall_mem", 32'(stall_mem), 32'd0);
    cmp("reset data_req", 32'(data_req), 32'd0);
    cmp("reset data_wr", 32'(data_wr), 32'd0);
    cmp("reset data_wstrb", 32'(data_wstrb), 32'd0);
    cmp("reset data_addr", data_addr, 32'd0);
    cmp("reset data_wdata", data_wdata, 32'd0);
    cmp("reset rdata", rdata, 32'd0);
    step();
    idle(2);

    // best-case load
    clearStats();
    runAccess(1'b0, 4'b1111, 32'h0000_1003, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
    cmp("load stall cycles", 32'(stallCycles), 32'd2);
    cmp("load req cycles", 32'(reqCycles), 32'd1);
    cmp("load data_addr", lastReqAddr, 32'h0000_1000);
    cmp("load data_wstrb", 32'(lastReqWstrb), 32'd0);
    cmp("load rdata", okRdata, 32'hDEAD_BEEF);
    idle(1);

    // store with addr_ok delayed three cycles
    clearStats();
    runAccess(1'b1, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 3, 1, 32'h0, 0);
    cmp("store req cycles", 32'(reqCycles), 32'd4);
    cmp("store data_wr", 32'(lastReqWr), 32'd1);
    cmp("store data_wstrb", 32'(lastReqWstrb), 32'b0100);
    cmp("store stall cycles", 32'(stallCycles), POSTED ? 32'd0 : 32'd6);
    idle(1);

    // load completing under m_hold, goes through DONE
    clearStats();
    runAccess(1'b0, 4'b1111, 32'h0000_2008, 32'h0, 1, 2, 32'h1234_5678, 2);
    cmp("hold stall cycles", 32'(stallCycles), 32'd5);
    cmp("hold req cycles", 32'(reqCycles), 32'd2);
    cmp("hold rdata", rdata, 32'h1234_5678);

    // back-to-back loads without a gap
    clearStats();
    runAccess(1'b0, 4'b1111, 32'h0000_3000, 32'h0, 0, 0, 32'h1111_1111, 0);
    runAccess(1'b0, 4'b0011, 32'h0000_3006, 32'h0, 0, 1, 32'h2222_2222, 0);
    cmp("b2b req cycles", 32'(reqCycles), 32'd2);
    cmp("b2b stall cycles", 32'(stallCycles), 32'd5);
    cmp("b2b last addr", lastReqAddr, 32'h0000_3004);

    // reset while waiting for data, then a stray data_ok
    memen = 1'b1; memwrite = 1'b0; sel = 4'hF; addr = 32'h0000_4000; m_hold = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    chk = 1'b1; expStall = 1'b1; expReq = 1'b0; chkRdata = 1'b0;
    step();
    expReq = 1'b1; expAddr = 32'h0000_4000; expWr = 1'b0; expWstrb = 4'h0; data_addr_ok = 1'b1;
    acceptedExp++;
    step();
    data_addr_ok = 1'b0; expReq = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1; memen = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBADB_AD00;
    expStall = 1'b0; chkRdata = 1'b1; expRdata = 32'h0;
    @(negedge clk);
    cmp("post-reset data_addr", data_addr, 32'd0);
    cmp("post-reset data_wstrb", 32'(data_wstrb), 32'd0);
    cmp("post-reset data_wdata", data_wdata, 32'd0);
    cmp("post-reset data_wr", 32'(data_wr), 32'd0);
    step();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    step();
    cmp("post-reset rdata_q", rdata, 32'd0);
    runAccess(1'b0, 4'b1111, 32'h0000_5000, 32'h0, 0, 0, 32'h5A5A_5A5A, 0);
    idle(1);

`ifdef DMEM_STORE_BUFFER_EN
    // posted store followed at once by a load; store drain completes four cycles after acceptance
    clearStats();
    for (int k = 0; k <= 8; k++) begin
      memen        = 1'b1;
      memwrite     = (k == 0);
      sel          = (k == 0) ? 4'b0011 : 4'b1111;
      addr         = (k == 0) ? 32'h0000_6000 : 32'h0000_7000;
      wdata        = (k == 0) ? 32'h0000_BEEF : 32'h0;
      m_hold       = 1'b0;
      data_addr_ok = (k == 1) || (k == 7);
      data_data_ok = (k == 5) || (k == 8);
      data_rdata   = (k == 8) ? 32'hCAFE_F00D : 32'h0;
      chk          = 1'b1;
      expStall     = (k >= 1) && (k < 8);
      expReq       = (k == 1) || (k == 7);
      expAddr      = (k == 1) ? 32'h0000_6000 : 32'h0000_7000;
      expWr        = (k == 1);
      expWstrb     = (k == 1) ? 4'b0011 : 4'b0000;
      expWdata     = 32'h0000_BEEF;
      chkRdata     = (k == 8);
      expRdata     = 32'hCAFE_F00D;
      step();
    end
    acceptedExp += 2;
    cmp("buffered stall cycles", 32'(stallCycles), 32'd7);
    cmp("buffered load rdata", okRdata, 32'hCAFE_F00D);
    idle(1);
`endif

    chk = 1'b0;
    cmp("accepted request count", 32'(acceptedSeen), 32'(acceptedExp));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the M stage of the pipelined MIPS datapath and a variable-latency data bus with split address/data handshakes. Accepts the M-stage access (word address, byte enables, store data), runs one bus transaction, and returns load data. Raises a stall that freezes the whole pipeline until the access completes.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; fixed at 32 (`sel` is 4 bits)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset (`rst`=0 resets on the next `clk` edge)
- `memen`  in  1  M stage holds a valid load/store
- `memwrite`  in  1  access is a store (meaningful only with `memen`)
- `sel`  in  4  byte enables from the M-stage byte-select logic
- `addr`  in  ADDR_W  M-stage ALU result (byte address)
- `wdata`  in  32  byte-lane-aligned store data
- `m_hold`  in  1  M stage frozen by another stall source this cycle
- `rdata`  out  32  load data to the M-stage load-extract logic
- `stall_mem`  out  1  freeze F/D/E/M; M-stage registers hold while high
- `data_req`  out  1  bus request valid
- `data_wr`  out  1  bus request is a write
- `data_wstrb`  out  4  write strobes (0000 on reads)
- `data_addr`  out  ADDR_W  `{addr[ADDR_W-1:2],2'b00}`
- `data_wdata`  out  32  write data
- `data_addr_ok`  in  1  bus accepted request this cycle
- `data_data_ok`  in  1  bus completed oldest accepted request this cycle
- `data_rdata`  in  32  read data, valid with `data_data_ok`

## Operation
- FSM: IDLE, REQ, WAIT, DONE.
- IDLE: `memen`=1 and no completed access pending -> latch `addr`/`sel`/`wdata`/`memwrite` into request registers, go REQ.
- REQ: `data_req`=1 with latched fields; `data_addr_ok`=1 -> WAIT (same cycle `data_req` observed high; drops next cycle).
- WAIT: `data_data_ok`=1 -> if `m_hold`=1 go DONE, else IDLE. Read data captured into `rdata_q`.
- DONE: access complete, M stage still frozen by `m_hold`; no reissue. `m_hold`=0 -> IDLE.
- `stall_mem` = `memen` & ~(WAIT & `data_data_ok`) & ~DONE.
- `rdata` = `data_rdata` when WAIT & `data_data_ok`, else `rdata_q`.
- At most one outstanding transaction; `data_data_ok` in IDLE/REQ/DONE ignored.
- `memen`=0 in IDLE: no request, `stall_mem`=0.

## Timing
- Reset: state IDLE; `data_req`, `data_wr`, `data_wstrb`, `data_addr`, `data_wdata`, `rdata_q` all 0; `stall_mem` follows formula (0 in IDLE unless `memen`).
- Best-case load: cycle 0 `memen` seen (stall=1); cycle 1 REQ + `addr_ok`; cycle 2 WAIT + `data_ok`, stall=0, `rdata` valid combinationally; pipeline advances at end of cycle 2.
- `data_addr_ok` and `data_data_ok` may not be high in the same cycle for the same request (bus property; bridge never treats REQ-cycle `data_ok` as completion).
- Request fields stable from REQ entry until `data_addr_ok`.
- Reset mid-transaction: FSM to IDLE, transaction abandoned; any late `data_data_ok` ignored.

## Configuration
- `DMEM_STORE_BUFFER_EN` defined: one-entry posted-write buffer. Store in IDLE with buffer empty captured into buffer, `stall_mem`=0 that cycle, buffer drains via REQ/WAIT. Store with buffer full stalls until drain completes, then enters buffer. Load while buffer busy stalls until drain done, then issues normally (no forwarding from buffer). DONE unused for stores.
- Undefined: stores follow the load flow, stalling until `data_data_ok`.

## Test plan
- Load, bus `addr_ok` in 1st REQ cycle, `data_ok` next cycle, `data_rdata`=0xDEADBEEF, `addr`=0x1003 -> `data_addr`=0x1000, `data_wstrb`=0000, stall high 2 cycles, `rdata`=0xDEADBEEF in cycle 2.
- Store `sel`=0100, `wdata`=0x00AB0000, `addr_ok` delayed 3 cycles -> `data_req` held 4 cycles with stable fields, `data_wr`=1, `data_wstrb`=0100; without macro stall until `data_ok`.
- Load completes while `m_hold`=1 for 2 cycles -> DONE, no second `data_req`, `rdata` holds captured value, stall_mem=0.
- `rst`=0 during WAIT, then stray `data_data_ok` -> outputs 0, state IDLE, no `rdata_q` update.
- Back-to-back loads, `memen` continuous -> second request latched the cycle after first completes, no gap loss or duplicate.
- With `DMEM_STORE_BUFFER_EN`: store then immediate load, store drain `data_ok` after 4 cycles -> store stall 0, load stalls until drain done, then normal load latency.
